// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the fixed-point matrix-vector sequencer.
package fp_ctrl_pkg;

    localparam int unsigned FP_WIDTH = 16;
    localparam int unsigned FP_FRAC  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CFG_M00   = 4'd0;
    localparam logic [3:0] CFG_M01   = 4'd1;
    localparam logic [3:0] CFG_M02   = 4'd2;
    localparam logic [3:0] CFG_M10   = 4'd3;
    localparam logic [3:0] CFG_M11   = 4'd4;
    localparam logic [3:0] CFG_M12   = 4'd5;
    localparam logic [3:0] CFG_M20   = 4'd6;
    localparam logic [3:0] CFG_M21   = 4'd7;
    localparam logic [3:0] CFG_M22   = 4'd8;
    localparam logic [3:0] CFG_BIAS0 = 4'd9;
    localparam logic [3:0] CFG_BIAS1 = 4'd10;
    localparam logic [3:0] CFG_BIAS2 = 4'd11;

    // Fixed-point 1.0 for a given number of fraction bits.
    function automatic logic [31:0] fp_one(input int unsigned frac);
        return 32'(1) << frac;
    endfunction

endpackage

// File: rtl/fp_mult.sv
// Signed fixed-point multiplier: full product rescaled to the operand Q format, saturated.
module fp_mult #(
    parameter int unsigned fp_width = 16,
    parameter int unsigned fp_frac  = 8
) (
    input  logic signed [fp_width-1:0] a,
    input  logic signed [fp_width-1:0] b,
    output logic signed [fp_width-1:0] p
);

    localparam int unsigned PW = 2 * fp_width;

    logic signed [PW-1:0] full;
    logic signed [PW-1:0] scaled;
    logic                 fits;

    // Rescale by the fraction width and clamp when the result leaves the Q range.
    always_comb begin
        full   = PW'(a) * PW'(b);
        scaled = full >>> fp_frac;
        fits   = (&scaled[PW-1:fp_width-1]) || !(|scaled[PW-1:fp_width-1]);
        if (fits) begin
            p = scaled[fp_width-1:0];
        end else if (scaled[PW-1]) begin
            p = {1'b1, {(fp_width-1){1'b0}}};
        end else begin
            p = {1'b0, {(fp_width-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fp_sat_add.sv
// Signed add at one extra bit of width, clamped back to the fp_width range.
module fp_sat_add #(
    parameter int unsigned fp_width = 16
) (
    input  logic signed [fp_width-1:0] a,
    input  logic signed [fp_width-1:0] b,
    output logic signed [fp_width-1:0] y
);

    logic signed [fp_width:0] sum;

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    always_comb begin
        sum = (fp_width+1)'(a) + (fp_width+1)'(b);
        if (sum[fp_width] == sum[fp_width-1]) begin
            y = sum[fp_width-1:0];
        end else if (sum[fp_width]) begin
            y = {1'b1, {(fp_width-1){1'b0}}};
        end else begin
            y = {1'b0, {(fp_width-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fp_matvec_seq.sv
// 3x3 fixed-point matrix plus bias applied to a 3-channel pixel through one shared multiplier.
module fp_matvec_seq
    import fp_ctrl_pkg::*;
#(
    parameter int unsigned fp_width = FP_WIDTH,
    parameter int unsigned fp_frac  = FP_FRAC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [fp_width-1:0] cfg_data,
    output logic                cfg_drop,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [fp_width-1:0] in_p0,
    input  logic [fp_width-1:0] in_p1,
    input  logic [fp_width-1:0] in_p2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [fp_width-1:0] out_c0,
    output logic [fp_width-1:0] out_c1,
    output logic [fp_width-1:0] out_c2,
    output logic                busy
);

    localparam logic signed [fp_width-1:0] ONE = fp_width'(fp_one(fp_frac));

    state_t                     state;
    logic signed [fp_width-1:0] coef [9];
    logic signed [fp_width-1:0] bias [3];
    logic signed [fp_width-1:0] pix  [3];
    logic signed [fp_width-1:0] acc  [3];
    logic [1:0]                 row;
    logic [1:0]                 col;

    logic signed [fp_width-1:0] coef_sel;
    logic signed [fp_width-1:0] pix_sel;
    logic signed [fp_width-1:0] acc_sel;
    logic signed [fp_width-1:0] product;
    logic signed [fp_width-1:0] acc_next;
    logic                       cfg_hit;

    // Operand selection for the current (row, col) step.
    always_comb begin
        coef_sel = coef[4'(row) * 4'd3 + 4'(col)];
        pix_sel  = pix[col];
        acc_sel  = acc[row];
        cfg_hit  = cfg_we && (cfg_addr <= CFG_BIAS2);
        in_ready = (state == ST_IDLE) && !cfg_we;
    end

    fp_mult #(
        .fp_width (fp_width),
        .fp_frac  (fp_frac)
    ) u_mult (
        .a (coef_sel),
        .b (pix_sel),
        .p (product)
    );

    fp_sat_add #(
        .fp_width (fp_width)
    ) u_add (
        .a (acc_sel),
        .b (product),
        .y (acc_next)
    );

    assign out_c0 = acc[0];
    assign out_c1 = acc[1];
    assign out_c2 = acc[2];

    // Sequencer, coefficient storage and handshake state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            cfg_drop  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                coef[i] <= (i % 4 == 0) ? ONE : '0;
            end
            for (int i = 0; i < 3; i++) begin
                bias[i] <= '0;
                pix[i]  <= '0;
                acc[i]  <= '0;
            end
        end else begin
            cfg_drop <= 1'b0;
            if (cfg_hit) begin
                if (state == ST_IDLE) begin
                    if (cfg_addr <= CFG_M22) begin
                        coef[cfg_addr] <= cfg_data;
                    end else begin
                        bias[2'(cfg_addr - CFG_BIAS0)] <= cfg_data;
                    end
                end else begin
                    cfg_drop <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        pix[0] <= in_p0;
                        pix[1] <= in_p1;
                        pix[2] <= in_p2;
                        for (int i = 0; i < 3; i++) begin
                            acc[i] <= bias[i];
                        end
                        row   <= '0;
                        col   <= '0;
                        state <= ST_MULT;
                        busy  <= 1'b1;
                    end
                end
                ST_MULT: begin
                    acc[row] <= acc_next;
                    if (col == 2'd2) begin
                        col <= '0;
                        if (row == 2'd2) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            row <= row + 2'd1;
                        end
                    end else begin
                        col <= col + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_matvec_seq.sv
// Self-checking bench for fp_matvec_seq against a plain-arithmetic matrix-vector model.
module tb_fp_matvec_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_drop;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_p0, in_p1, in_p2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_c0, out_c1, out_c2;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int mm [9];
    int bb [3];
    int ec [3];

    fp_matvec_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_drop  (cfg_drop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p0     (in_p0),
        .in_p1     (in_p1),
        .in_p2     (in_p2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c0    (out_c0),
        .out_c1    (out_c1),
        .out_c2    (out_c2),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sat(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic int mulq(input int a, input int b);
        longint pr;
        pr = longint'(a) * longint'(b);
        return sat(pr >>> 8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mm[i] = (i % 4 == 0) ? 256 : 0;
        for (int i = 0; i < 3; i++) bb[i] = 0;
    endtask

    // c_i = bias_i + M[i][0]*p0 + M[i][1]*p1 + M[i][2]*p2, saturating after each term.
    task automatic model_eval(input int p0, input int p1, input int p2);
        int p [3];
        p[0] = p0; p[1] = p1; p[2] = p2;
        for (int r = 0; r < 3; r++) begin
            ec[r] = bb[r];
            for (int c = 0; c < 3; c++) ec[r] = sat(longint'(ec[r]) + longint'(mulq(mm[3*r+c], p[c])));
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Configuration write issued while the block is idle.
    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        if (a < 4'd9) mm[a] = s16(d);
        else if (a < 4'd12) bb[a - 4'd9] = s16(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Offer a pixel, check acceptance and latency, leave the result held in DONE.
    task automatic start_and_wait(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                                  input string tag);
        int lat;
        @(negedge clk);
        cfg_we = 1'b0;
        in_valid = 1'b1; in_p0 = p0; in_p1 = p1; in_p2 = p2;
        #1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        model_eval(s16(p0), s16(p1), s16(p2));
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_c0"}, s16(out_c0), ec[0]);
        chk({tag, "_c1"}, s16(out_c1), ec[1]);
        chk({tag, "_c2"}, s16(out_c2), ec[2]);
    endtask

    // Stall for a number of cycles, then complete the output handshake.
    task automatic drain(input int hold, input string tag);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_stall_valid"}, int'(out_valid), 1);
            chk({tag, "_stall_c0"}, s16(out_c0), ec[0]);
            chk({tag, "_stall_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, int'(out_valid), 0);
        chk({tag, "_release_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_p0 = '0; in_p1 = '0; in_p2 = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_drop", int'(cfg_drop), 0);
        chk("rst_c0", s16(out_c0), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;

        // Identity pass-through.
        start_and_wait(16'h0100, 16'h0200, 16'h0300, "ident");
        chk("ident_c1_const", s16(out_c1), 'h0200);
        drain(0, "ident");

        // Weighted row 0 with negative bias.
        cfg_write(4'd0, 16'h0080);
        cfg_write(4'd1, 16'h0080);
        cfg_write(4'd2, 16'h0000);
        cfg_write(4'd9, 16'hFFC0);
        start_and_wait(16'h0200, 16'h0400, 16'h7FFF, "wsum");
        chk("wsum_c0_const", s16(out_c0), 'h02C0);
        drain(1, "wsum");

        // Positive and negative saturation.
        cfg_write(4'd0, 16'h0100);
        cfg_write(4'd1, 16'h0100);
        cfg_write(4'd2, 16'h0100);
        start_and_wait(16'h6400, 16'h6400, 16'h6400, "satp");
        chk("satp_c0_const", s16(out_c0), 32767);
        drain(0, "satp");
        start_and_wait(16'h9C00, 16'h9C00, 16'h9C00, "satn");
        chk("satn_c0_const", s16(out_c0), -32768);

        // Long stall with a write that must be dropped.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 16'h0300;
            end else begin
                cfg_we = 1'b0;
            end
            if (k == 2) chk("drop_pulse", int'(cfg_drop), 1);
            else chk("drop_quiet", int'(cfg_drop), 0);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_c0", s16(out_c0), ec[0]);
            chk("stall_c1", s16(out_c1), ec[1]);
            chk("stall_in_ready", int'(in_ready), 0);
            @(posedge clk);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        drain(0, "satn");
        start_and_wait(16'h0000, 16'h0500, 16'h0000, "m11kept");
        chk("m11kept_c1_const", s16(out_c1), 'h0500);
        drain(0, "m11kept");

        // Config write and pixel offered together: write wins, pixel taken next cycle.
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'h0200;
        in_valid = 1'b1; in_p0 = 16'h0150; in_p1 = 16'h0000; in_p2 = 16'h0000;
        #1;
        chk("collide_in_ready", int'(in_ready), 0);
        @(posedge clk);
        mm[0] = 'h0200;
        start_and_wait(16'h0150, 16'h0000, 16'h0000, "collide");
        chk("collide_c0_const", s16(out_c0), 'h02A0 + bb[0]);
        drain(0, "collide");

        // Reset during MULT step 4 aborts the pixel and restores defaults.
        @(negedge clk);
        in_valid = 1'b1; in_p0 = 16'h0300; in_p1 = 16'h0300; in_p2 = 16'h0300;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", int'(seen), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        start_and_wait(16'h0100, 16'h0000, 16'h0000, "postrst");
        chk("postrst_c0_const", s16(out_c0), 'h0100);
        drain(0, "postrst");

        // Randomized configurations and pixels.
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 3; w++) begin
                cfg_write(4'($urandom_range(0, 15)),
                          16'(int'($urandom_range(0, 2047)) - 1024));
            end
            start_and_wait(16'($urandom), 16'($urandom), 16'($urandom), $sformatf("rnd%0d", it));
            drain(int'($urandom_range(0, 3)), $sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
